if_id_queue: RTL and testbench

Parametrised IF/ID boundary buffer: a DEPTH-entry circular FIFO of (pc, inst) pairs between the fetch unit and decode. It replaces the single-entry IF/ID register, so fetch can run ahead while decode stalls. It uses valid/ready handshakes on both sides, a synchronous flush for branch/jump redirect, and an optional same-cycle bypass when empty. Decode sees a zero pc/inst bubble whenever no entry is valid.

---
 rtl/if_id_queue.sv | 93 +++++++++
 tb/tb_if_id_queue.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
// IF/ID boundary buffer: DEPTH-entry circular FIFO of (pc, inst) pairs between fetch and decode.
// Optional feature macro: IFQ_BYPASS_EN (same-cycle fetch->decode bypass when the queue is empty).
module if_id_queue #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     if_valid_i,
    input  logic [ADDR_W-1:0]        if_pc_i,
    input  logic [INST_W-1:0]        if_inst_i,
    output logic                     if_ready_o,
    output logic                     id_valid_o,
    output logic [ADDR_W-1:0]        id_pc_o,
    output logic [INST_W-1:0]        id_inst_o,
    input  logic                     id_ready_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic bypass_take;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                     (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
    assign count_o = wr_ptr - rd_ptr;

    assign if_ready_o = !full && !rst;

`ifdef IFQ_BYPASS_EN
    // An instruction decode takes straight from fetch never occupies an entry.
    assign bypass_take = empty && !flush_i && if_valid_i && id_ready_i;
`else
    assign bypass_take = 1'b0;
`endif

    assign push = if_valid_i && if_ready_o && !bypass_take;
    assign pop  = !empty && id_ready_i;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push && !flush_i) begin
            pc_mem[wr_ptr[IDX_W-1:0]]   <= if_pc_i;
            inst_mem[wr_ptr[IDX_W-1:0]] <= if_inst_i;
        end
    end

    // NOTE: defaults first keep this block free of inferred latches.
    always_comb begin
        id_valid_o = 1'b0;
        id_pc_o    = '0;
        id_inst_o  = '0;
        if (!empty) begin
            id_valid_o = 1'b1;
            id_pc_o    = pc_mem[rd_ptr[IDX_W-1:0]];
            id_inst_o  = inst_mem[rd_ptr[IDX_W-1:0]];
        end
`ifdef IFQ_BYPASS_EN
        else if (!flush_i && !rst && if_valid_i) begin
            id_valid_o = 1'b1;
            id_pc_o    = if_pc_i;
            id_inst_o  = if_inst_i;
        end
`endif
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue (DEPTH = 4); adapts the bypass step to IFQ_BYPASS_EN.
module tb_if_id_queue;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic        if_valid_i;
    logic [31:0] if_pc_i;
    logic [31:0] if_inst_i;
    logic        if_ready_o;
    logic        id_valid_o;
    logic [31:0] id_pc_o;
    logic [31:0] id_inst_o;
    logic        id_ready_i;
    logic [2:0]  count_o;

    int tests_run;
    int tests_failed;

    if_id_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush_i),
        .if_valid_i (if_valid_i),
        .if_pc_i    (if_pc_i),
        .if_inst_i  (if_inst_i),
        .if_ready_o (if_ready_o),
        .id_valid_o (id_valid_o),
        .id_pc_o    (id_pc_o),
        .id_inst_o  (id_inst_o),
        .id_ready_i (id_ready_i),
        .count_o    (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock edge and sample 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst        = 1'b1;
        flush_i    = 1'b0;
        if_valid_i = 1'b1;
        if_pc_i    = 32'h100;
        if_inst_i  = 32'hDEAD_0000;
        id_ready_i = 1'b0;

        // Reset held two cycles with fetch presenting.
        tick();
        check("rst_ready_c1", 64'(if_ready_o), 64'd0);
        tick();
        check("rst_ready_c2", 64'(if_ready_o), 64'd0);
        rst        = 1'b0;
        if_valid_i = 1'b0;
        #1;
        check("post_rst_valid", 64'(id_valid_o), 64'd0);
        check("post_rst_pc",    64'(id_pc_o),    64'd0);
        check("post_rst_inst",  64'(id_inst_o),  64'd0);
        check("post_rst_count", 64'(count_o),    64'd0);
        check("post_rst_ready", 64'(if_ready_o), 64'd1);

        // Fill with decode stalled.
        for (int i = 0; i < 4; i++) begin
            if_valid_i = 1'b1;
            if_pc_i    = 32'(i * 4);
            if_inst_i  = 32'h1000 + 32'(i);
            tick();
        end
        if_valid_i = 1'b0;
        #1;
        check("full_count", 64'(count_o),    64'd4);
        check("full_ready", 64'(if_ready_o), 64'd0);
        check("full_head",  64'(id_pc_o),    64'h0);

        // Fifth push while full is ignored.
        if_valid_i = 1'b1;
        if_pc_i    = 32'h10;
        if_inst_i  = 32'h1004;
        tick();
        if_valid_i = 1'b0;
        #1;
        check("ovf_count",     64'(count_o),   64'd4);
        check("ovf_head_pc",   64'(id_pc_o),   64'h0);
        check("ovf_head_inst", 64'(id_inst_o), 64'h1000);

        // Drain in order.
        id_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_pc_%0d", i),   64'(id_pc_o),   64'(i * 4));
            check($sformatf("drain_inst_%0d", i), 64'(id_inst_o), 64'h1000 + 64'(i));
            tick();
        end
        id_ready_i = 1'b0;
        #1;
        check("drained_valid", 64'(id_valid_o), 64'd0);
        check("drained_pc",    64'(id_pc_o),    64'd0);
        check("drained_inst",  64'(id_inst_o),  64'd0);
        check("drained_count", 64'(count_o),    64'd0);

        // Prime two entries, then stream with simultaneous push/pop across pointer wraps.
        for (int i = 0; i < 2; i++) begin
            if_valid_i = 1'b1;
            if_pc_i    = 32'h200 + 32'(i * 4);
            if_inst_i  = 32'h2000 + 32'(i);
            tick();
        end
        id_ready_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if_valid_i = 1'b1;
            if_pc_i    = 32'h208 + 32'(k * 4);
            if_inst_i  = 32'h2002 + 32'(k);
            #1;
            check($sformatf("stream_count_%0d", k), 64'(count_o),  64'd2);
            check($sformatf("stream_pc_%0d", k),    64'(id_pc_o),  64'h200 + 64'(k * 4));
            tick();
        end
        id_ready_i = 1'b0;
        // Third entry for the flush test: queue holds 0x228, 0x22C, 0x230.
        if_pc_i   = 32'h230;
        if_inst_i = 32'h200C;
        tick();
        if_valid_i = 1'b0;
        #1;
        check("pre_flush_count", 64'(count_o), 64'd3);
        check("pre_flush_head",  64'(id_pc_o), 64'h228);

        // Flush with a simultaneous push and pop; both are discarded.
        flush_i    = 1'b1;
        if_valid_i = 1'b1;
        if_pc_i    = 32'h20;
        if_inst_i  = 32'h3000;
        id_ready_i = 1'b1;
        tick();
        flush_i    = 1'b0;
        if_valid_i = 1'b0;
        id_ready_i = 1'b0;
        #1;
        check("flush_count", 64'(count_o),    64'd0);
        check("flush_valid", 64'(id_valid_o), 64'd0);
        check("flush_ready", 64'(if_ready_o), 64'd1);

        if_valid_i = 1'b1;
        if_pc_i    = 32'h40;
        if_inst_i  = 32'h4000;
        tick();
        if_valid_i = 1'b0;
        #1;
        check("post_flush_valid", 64'(id_valid_o), 64'd1);
        check("post_flush_pc",    64'(id_pc_o),    64'h40);
        check("post_flush_inst",  64'(id_inst_o),  64'h4000);
        check("post_flush_count", 64'(count_o),    64'd1);

        id_ready_i = 1'b1;
        tick();
        id_ready_i = 1'b0;
        #1;
        check("empty_again", 64'(count_o), 64'd0);

        // Empty queue, fetch presents while decode is ready.
        if_valid_i = 1'b1;
        if_pc_i    = 32'h80;
        if_inst_i  = 32'h8000;
        id_ready_i = 1'b1;
        #1;
`ifdef IFQ_BYPASS_EN
        check("byp_same_valid", 64'(id_valid_o), 64'd1);
        check("byp_same_pc",    64'(id_pc_o),    64'h80);
        check("byp_same_count", 64'(count_o),    64'd0);
`else
        check("nobyp_same_valid", 64'(id_valid_o), 64'd0);
        check("nobyp_same_pc",    64'(id_pc_o),    64'd0);
`endif
        tick();
        if_valid_i = 1'b0;
        id_ready_i = 1'b0;
        #1;
`ifdef IFQ_BYPASS_EN
        check("byp_next_valid", 64'(id_valid_o), 64'd0);
        check("byp_next_count", 64'(count_o),    64'd0);
`else
        check("nobyp_next_valid", 64'(id_valid_o), 64'd1);
        check("nobyp_next_pc",    64'(id_pc_o),    64'h80);
        check("nobyp_next_count", 64'(count_o),    64'd1);
`endif

        // Reset mid-operation with entries present and a push in flight.
        if_valid_i = 1'b1;
        if_pc_i    = 32'h90;
        if_inst_i  = 32'h9000;
        tick();
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        if_valid_i = 1'b0;
        #1;
        check("mid_rst_count", 64'(count_o),    64'd0);
        check("mid_rst_valid", 64'(id_valid_o), 64'd0);
        check("mid_rst_pc",    64'(id_pc_o),    64'd0);
        check("mid_rst_ready", 64'(if_ready_o), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
